// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit order,
// the blank pattern and the hex glyph table, plus the lookup helper.
package seg7_pkg;

  // Segment bus is {g,f,e,d,c,b,a}; bit positions within the bus.
  localparam int SEG_W     = 7;
  localparam int SEG_A_BIT = 0;
  localparam int SEG_B_BIT = 1;
  localparam int SEG_C_BIT = 2;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 4;
  localparam int SEG_F_BIT = 5;
  localparam int SEG_G_BIT = 6;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F = 7'h71;

  // Index 0 holds the glyph for hex digit 0.
  localparam logic [15:0][SEG_W-1:0] SEG_HEX = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  function automatic logic [SEG_W-1:0] hex_encode(input logic [3:0] h);
    return SEG_HEX[h];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load/data/mask inputs and display outputs of the scan driver, grouped.
// master = the side that supplies digits; slave = the driver itself.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    pending;
  logic                    update_ack;

  modport master (
    output load, data, blank_mask,
    input  seg, digit_en, pending, update_ack
  );

  modport slave (
    input  load, data, blank_mask,
    output seg, digit_en, pending, update_ack
  );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to {g..a} segment pattern lookup.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_W-1:0] seg
);

  // Table lookup only; no state.
  always_comb seg = hex_encode(hex);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-segment 7-segment display driver.
// Digits are double-buffered: loads land in a shadow register and are
// committed to the displayed register only on the frame-end tick.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN darkens leading zero
// digits (never digit 0) of the committed display value.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int CNT_W  = $clog2(PRESCALE);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DATA_W = 4 * NUM_DIGITS;

  logic [CNT_W-1:0]      cnt_p0;
  logic [IDX_W-1:0]      idx_p0;
  logic [DATA_W-1:0]     display_p0;
  logic [DATA_W-1:0]     shadow_p0;
  logic                  pending_p0;

  logic                  tick;
  logic                  frame_end;
  logic                  commit;
  logic [3:0]            nib;
  logic [SEG_W-1:0]      nib_seg;
  logic [NUM_DIGITS-1:0] en_sel;
  logic                  blank_sel;
  logic [NUM_DIGITS-1:0] lz_blank;

  logic [SEG_W-1:0]      seg_p1;
  logic [NUM_DIGITS-1:0] digit_en_p1;
  logic                  ack_p1;

  // Slot timing and commit decision.
  always_comb begin
    tick      = (cnt_p0 == CNT_W'(PRESCALE - 1));
    frame_end = tick && (idx_p0 == IDX_W'(NUM_DIGITS - 1));
    commit    = frame_end && pending_p0;
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic above_zero;

  // Walk down from the top digit; a digit is dark while it and all above are zero.
  always_comb begin
    lz_blank   = '0;
    above_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      above_zero  = above_zero && (display_p0[4*i +: 4] == 4'h0);
      lz_blank[i] = above_zero;
    end
  end
`else
  // Leading zeros display normally.
  always_comb lz_blank = '0;
`endif

  // Select the nibble, enable and blanking for the active slot.
  always_comb begin
    nib       = '0;
    en_sel    = '0;
    blank_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_p0 == IDX_W'(i)) begin
        nib       = display_p0[4*i +: 4];
        en_sel[i] = 1'b1;
        blank_sel = bus.blank_mask[i] | lz_blank[i];
      end
    end
  end

  hex_to_seg7 u_enc (
    .hex (nib),
    .seg (nib_seg)
  );

  // Prescaler, slot index and the double-buffered digit registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_p0     <= '0;
      idx_p0     <= '0;
      display_p0 <= '0;
      shadow_p0  <= '0;
      pending_p0 <= 1'b0;
      ack_p1     <= 1'b0;
    end else begin
      cnt_p0 <= tick ? '0 : cnt_p0 + CNT_W'(1);
      if (tick) begin
        idx_p0 <= (idx_p0 == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_p0 + IDX_W'(1);
      end
      if (commit) begin
        display_p0 <= shadow_p0;
      end
      // A load on the frame-end tick refills the shadow after the old value commits.
      if (bus.load) begin
        shadow_p0 <= bus.data;
      end
      pending_p0 <= bus.load | (pending_p0 & ~commit);
      ack_p1     <= commit;
    end
  end

  // Registered outputs; the cycle after each tick is dead time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_p1      <= SEG_OFF;
      digit_en_p1 <= '0;
    end else if (tick || blank_sel) begin
      seg_p1      <= SEG_OFF;
      digit_en_p1 <= '0;
    end else begin
      seg_p1      <= nib_seg;
      digit_en_p1 <= en_sel;
    end
  end

  assign bus.seg        = seg_p1;
  assign bus.digit_en   = digit_en_p1;
  assign bus.pending    = pending_p0;
  assign bus.update_ack = ack_p1;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a common-segment multi-digit 7-segment display.
- Holds a register of hex digits and scans them one at a time onto a shared segment bus, asserting one digit enable per slot.
- Acts as the demultiplexing, output end of the digit-select path.
- New values are double-buffered and committed only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
NUM_DIGITS, 4, number of digits scanned; must be >= 1.
PRESCALE, 50000, clock cycles per digit slot; must be >= 2.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
load  input  1  single-cycle strobe; capture data into the shadow register
data  input  4*NUM_DIGITS  hex digits; data[3:0] is digit 0 (rightmost)
blank_mask  input  NUM_DIGITS  bit i=1 forces digit i dark
seg  output  7  segments {g,f,e,d,c,b,a}, active-high, registered
digit_en  output  NUM_DIGITS  one-hot digit enable, active-high, registered
pending  output  1  shadow holds an uncommitted value
update_ack  output  1  one-cycle pulse when the shadow is committed to the display

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - prescale counter=0, index=0, display reg=0, shadow=0, pending=0.
  - seg=0, digit_en=0, update_ack=0.
  - Reset applies mid-frame or mid-pending with no exceptions; a pending load is discarded.
- Prescale counter:
  - Counts 0..PRESCALE-1. tick = (count==PRESCALE-1), after which count wraps to 0.
  - On tick, index advances; it wraps from NUM_DIGITS-1 to 0.
  - A tick with index==NUM_DIGITS-1 is the frame-end tick.
- Dead time:
  - In the cycle after any tick, seg=0 and digit_en=0.
  - From the second cycle after the tick, the new slot is driven. Each slot therefore shows for PRESCALE-1 cycles.
  - After reset release, slot 0 is driven from the first cycle after release.
- Slot output:
  - digit_en=1<<index.
  - seg=encode(display[4*index+:4]), registered, so seg and digit_en change on the same edge.
  - If blank_mask[index]=1, seg=0 and digit_en=0 for the whole slot. blank_mask is sampled live each cycle.
- Encoding (hex): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Load handshake:
  - load=1 -> shadow<=data, pending<=1. load is always accepted; the last write before the frame end wins.
  - On the frame-end tick with pending=1 -> display<=shadow, pending<=0, update_ack=1 for the next cycle only.
  - The new display takes effect from slot 0 of the next frame.
  - load coincident with the frame-end tick: the pre-existing shadow (if pending) is committed and acked. The new data is captured and pending stays 1 for the following frame.
  - If load arrives on that tick with pending previously 0, nothing is committed this frame and pending=1 afterwards.
- No combinational path from any input to any output.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Any display digit that is 0 and has only zero digits above it is treated as blanked (seg=0, digit_en=0), OR-ed with blank_mask.
  - Digit 0 is never blanked by this rule.
  - Evaluated on the committed display reg, not the shadow.
- Undefined: zero digits always display 3F unless masked.

Decomposition:
- Package seg7_pkg holds:
  - SEG_OFF=7'h00.
  - The 16-entry hex segment constants.
  - The function/width constants for the {g..a} bit ordering.
- Sub-module hex_to_seg7 (4-bit in, 7-bit out, purely combinational table lookup) is instantiated once on the selected nibble.

Test Plan:
All scenarios use NUM_DIGITS=4, PRESCALE=4.
1. Reset: hold rst_n=0 3 cycles -> seg=0, digit_en=0, pending=0, update_ack=0. Release -> digit_en=0001, seg=3F. After the tick, one cycle of 0/0, then digit_en=0010, seg=3F.
2. Single load: pulse load with data=16'h1234 mid-frame -> pending=1 until the frame-end tick, then a single update_ack pulse. Next frame shows 0001:66, 0010:4F, 0100:5B, 1000:06.
3. Double load: loads of 16'h1111 then 16'hABCD in the same frame -> exactly one update_ack. Display shows d,C,b,A = 5E,39,7C,77 for digits 0..3.
4. Blank mask: blank_mask=4'b1000 with display 16'h1234 -> during slot 3, digit_en=0 and seg=0. Other slots are unchanged.
5. Mid-operation reset: rst_n=0 while pending=1 -> pending=0, no update_ack. Display reverts to all 3F after release.
6. With SEG7_LEADING_ZERO_BLANK_EN: data=16'h00A0 -> slots 3 and 2 dark, slot 1 = 77, slot 0 = 3F. With data=16'h0000, only slot 0 is lit (3F). Without the macro, all four slots show their digit.
